// File: rtl/hes_msg_feeder.sv
// Message feeder for the hash core: byte FIFO, start/F_dr/End_of_File handshake, digest capture.
// Optional byte counter and length-error flag when HES_FEED_BYTECNT_EN is defined.
module hes_msg_feeder #(
  parameter int DEPTH   = 16,
  parameter int H_WIDTH = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [7:0]         wr_data,
  input  logic               wr_last,
  output logic               full,
  output logic               ovf,
  input  logic               cmd_go,
  input  logic               cmd_empty,
  output logic               start,
  output logic               F_dr,
  output logic [7:0]         M,
  input  logic               F_rtr,
  output logic               End_of_File,
  input  logic               H_ready,
  input  logic [H_WIDTH-1:0] h_in,
  output logic [H_WIDTH-1:0] digest,
  output logic               digest_valid,
  output logic               busy
`ifdef HES_FEED_BYTECNT_EN
  ,
  output logic [31:0]        byte_cnt,
  output logic               len_err
`endif
);

  // state  | meaning
  // IDLE   | waiting for cmd_go; FIFO may be preloaded
  // ARM    | start asserted until first handshake (or F_rtr for an empty message)
  // STREAM | one byte per handshake until the last-marked byte is popped
  // WAIT_H | End_of_File held until the core reports H_ready
  typedef enum logic [1:0] {IDLE, ARM, STREAM, WAIT_H} state_t;

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  state_t             state_q, state_d;
  logic [8:0]         mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               empty_msg_q, empty_msg_d;
  logic               eof_flag_q, eof_flag_d;
  logic               digest_valid_q, digest_valid_d;
  logic [H_WIDTH-1:0] digest_q, digest_d;
  logic               fifo_empty, do_wr, do_rd, go_acc;
  logic [8:0]         head;

  assign fifo_empty   = (count_q == '0);
  assign full         = (count_q == CNT_FULL);
  assign head         = mem_q[rd_ptr_q];
  assign M            = fifo_empty ? 8'h00 : head[7:0];
  assign do_wr        = wr_en & ~full;
  assign do_rd        = F_dr & F_rtr;
  assign ovf          = ovf_q;
  assign digest       = digest_q;
  assign digest_valid = digest_valid_q;
  assign busy         = (state_q != IDLE);

  always_comb begin
    state_d        = state_q;
    start          = 1'b0;
    F_dr           = 1'b0;
    End_of_File    = 1'b0;
    go_acc         = 1'b0;
    empty_msg_d    = empty_msg_q;
    eof_flag_d     = eof_flag_q;
    digest_d       = digest_q;
    digest_valid_d = digest_valid_q;
    case (state_q)
      IDLE: begin
        if (cmd_go) begin
          go_acc         = 1'b1;
          state_d        = ARM;
          digest_valid_d = 1'b0;
          empty_msg_d    = cmd_empty;
          eof_flag_d     = 1'b0;
        end
      end
      ARM: begin
        start = 1'b1;
        if (empty_msg_q) begin
          End_of_File = 1'b1;
          if (F_rtr) state_d = WAIT_H;
        end else begin
          F_dr = ~fifo_empty;
          if (~fifo_empty && F_rtr) begin
            state_d    = STREAM;
            eof_flag_d = head[8];
          end
        end
      end
      STREAM: begin
        if (eof_flag_q) begin
          End_of_File = 1'b1;
          state_d     = WAIT_H;
        end else begin
          F_dr = ~fifo_empty;
          if (~fifo_empty && F_rtr && head[8]) eof_flag_d = 1'b1;
        end
      end
      WAIT_H: begin
        End_of_File = 1'b1;
        if (H_ready) begin
          digest_d       = h_in;
          digest_valid_d = 1'b1;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // full is judged before any same-cycle pop, so a write while full is always dropped
  always_comb begin
    wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (do_wr && !do_rd) count_d = count_q + 1'b1;
    else if (!do_wr && do_rd) count_d = count_q - 1'b1;
    ovf_d = go_acc ? 1'b0 : ovf_q;
    if (wr_en && full) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= {wr_last, wr_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      ovf_q          <= 1'b0;
      empty_msg_q    <= 1'b0;
      eof_flag_q     <= 1'b0;
      digest_valid_q <= 1'b0;
      digest_q       <= '0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      ovf_q          <= ovf_d;
      empty_msg_q    <= empty_msg_d;
      eof_flag_q     <= eof_flag_d;
      digest_valid_q <= digest_valid_d;
      digest_q       <= digest_d;
    end
  end

`ifdef HES_FEED_BYTECNT_EN
  logic [31:0] byte_cnt_q, byte_cnt_d;
  logic        len_err_q, len_err_d;
  logic        wait_entry;

  assign wait_entry = (state_d == WAIT_H) && (state_q != WAIT_H);
  assign byte_cnt   = byte_cnt_q;
  assign len_err    = len_err_q;

  // a non-empty message reaching WAIT_H with no bytes counted means the handshake logic is broken
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    len_err_d  = len_err_q;
    if (go_acc) begin
      byte_cnt_d = '0;
      len_err_d  = 1'b0;
    end else begin
      if (do_rd && byte_cnt_q != '1) byte_cnt_d = byte_cnt_q + 1'b1;
      if (wait_entry && byte_cnt_q == '0 && !empty_msg_q) len_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_q <= '0;
      len_err_q  <= 1'b0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      len_err_q  <= len_err_d;
    end
  end
`endif

endmodule

// File: tb/tb_hes_msg_feeder.sv
// Directed self-checking bench for hes_msg_feeder (default build, DEPTH=16, H_WIDTH=64).
module tb_hes_msg_feeder;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst, wr_en, wr_last, cmd_go, cmd_empty, F_rtr, H_ready;
  logic [7:0]  wr_data, M;
  logic [63:0] h_in, digest;
  logic        full, ovf, start, F_dr, End_of_File, digest_valid, busy;

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  hes_msg_feeder #(.DEPTH(DEPTH), .H_WIDTH(64)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_last(wr_last),
    .full(full), .ovf(ovf), .cmd_go(cmd_go), .cmd_empty(cmd_empty),
    .start(start), .F_dr(F_dr), .M(M), .F_rtr(F_rtr), .End_of_File(End_of_File),
    .H_ready(H_ready), .h_in(h_in), .digest(digest), .digest_valid(digest_valid),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic [7:0] b, input logic last);
    wr_en = 1'b1; wr_data = b; wr_last = last;
    tick();
    wr_en = 1'b0; wr_last = 1'b0;
  endtask

  task automatic go(input logic empty);
    cmd_go = 1'b1; cmd_empty = empty;
    tick();
    cmd_go = 1'b0; cmd_empty = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_start"}, 64'(start), 64'd0);
    chk({tag, "_fdr"}, 64'(F_dr), 64'd0);
    chk({tag, "_eof"}, 64'(End_of_File), 64'd0);
    chk({tag, "_ovf"}, 64'(ovf), 64'd0);
    chk({tag, "_dvalid"}, 64'(digest_valid), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_full"}, 64'(full), 64'd0);
    chk({tag, "_digest"}, digest, 64'd0);
    chk({tag, "_m"}, 64'(M), 64'd0);
  endtask

  // F_rtr high one cycle in every `period`; checks order, stall stability and handshake count
  task automatic collect(input int period, input string tag);
    int hs = 0;
    int n = exp_q.size();
    bit prev_stall = 1'b0;
    logic [7:0] prev_m = 8'h00;
    for (int c = 0; c < 400 && !End_of_File; c++) begin
      F_rtr = ((c % period) == (period - 1));
      #1;
      if (prev_stall) begin
        chk({tag, "_stall_fdr"}, 64'(F_dr), 64'd1);
        chk({tag, "_stall_m"}, 64'(M), 64'(prev_m));
      end
      if (F_dr && F_rtr) begin
        if (hs < n) chk({tag, "_byte"}, 64'(M), 64'(exp_q[hs]));
        hs++;
      end
      prev_stall = F_dr && !F_rtr;
      prev_m = M;
      tick();
    end
    F_rtr = 1'b0;
    chk({tag, "_eof_seen"}, 64'(End_of_File), 64'd1);
    chk({tag, "_hs_cnt"}, 64'(hs), 64'(n));
    exp_q.delete();
  endtask

  task automatic finish_digest(input logic [63:0] h, input string tag);
    chk({tag, "_eof_wait"}, 64'(End_of_File), 64'd1);
    chk({tag, "_fdr_wait"}, 64'(F_dr), 64'd0);
    H_ready = 1'b1; h_in = h;
    tick();
    H_ready = 1'b0;
    chk({tag, "_digest"}, digest, h);
    chk({tag, "_dvalid"}, 64'(digest_valid), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_eof_drop"}, 64'(End_of_File), 64'd0);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; wr_last = 1'b0;
    cmd_go = 1'b0; cmd_empty = 1'b0; F_rtr = 1'b0; H_ready = 1'b0; h_in = '0;
    tick(); tick();
    rst = 1'b0;
    chk_reset_outputs("rst");

    // basic three-byte message, core always ready
    wr_byte(8'hA1, 1'b0); wr_byte(8'hB2, 1'b0); wr_byte(8'hC3, 1'b1);
    chk("pre_m", 64'(M), 64'hA1);
    chk("pre_fdr", 64'(F_dr), 64'd0);
    go(1'b0);
    chk("arm_start", 64'(start), 64'd1);
    chk("arm_fdr", 64'(F_dr), 64'd1);
    chk("arm_m", 64'(M), 64'hA1);
    F_rtr = 1'b1;
    tick();
    chk("s1_start", 64'(start), 64'd0);
    chk("s1_m", 64'(M), 64'hB2);
    chk("s1_fdr", 64'(F_dr), 64'd1);
    tick();
    chk("s2_m", 64'(M), 64'hC3);
    chk("s2_eof", 64'(End_of_File), 64'd0);
    tick();
    F_rtr = 1'b0;
    chk("s3_eof", 64'(End_of_File), 64'd1);
    chk("s3_fdr", 64'(F_dr), 64'd0);
    chk("s3_busy", 64'(busy), 64'd1);
    tick();
    finish_digest(64'h0123_4567_89AB_CDEF, "msg1");

    // empty message
    go(1'b1);
    chk("em_start", 64'(start), 64'd1);
    chk("em_eof", 64'(End_of_File), 64'd1);
    chk("em_fdr", 64'(F_dr), 64'd0);
    chk("em_dvalid_clr", 64'(digest_valid), 64'd0);
    tick();
    chk("em_hold_start", 64'(start), 64'd1);
    F_rtr = 1'b1;
    tick();
    F_rtr = 1'b0;
    chk("em_wait_start", 64'(start), 64'd0);
    finish_digest(64'hDEAD_BEEF_0000_0001, "empty");

    // backpressure: five bytes, ready one cycle in eight
    wr_byte(8'h11, 1'b0); wr_byte(8'h22, 1'b0); wr_byte(8'h33, 1'b0);
    wr_byte(8'h44, 1'b0); wr_byte(8'h55, 1'b1);
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    go(1'b0);
    collect(8, "bp");
    tick();
    finish_digest(64'h5555_AAAA_5555_AAAA, "bp");

    // overflow: DEPTH+1 writes in IDLE, last one dropped
    for (int i = 0; i < DEPTH; i++) wr_byte(8'h40 + 8'(i), (i == DEPTH - 1));
    chk("ovf_full", 64'(full), 64'd1);
    chk("ovf_pre", 64'(ovf), 64'd0);
    wr_byte(8'hEE, 1'b1);
    chk("ovf_set", 64'(ovf), 64'd1);
    chk("ovf_still_full", 64'(full), 64'd1);
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(8'h40 + 8'(i));
    go(1'b0);
    chk("ovf_clr", 64'(ovf), 64'd0);
    collect(1, "ovf");
    tick();
    finish_digest(64'h0000_0000_0000_0010, "ovf");
    chk("ovf_fifo_empty", 64'(full), 64'd0);
    chk("ovf_m_empty", 64'(M), 64'd0);

    // streaming underrun
    wr_byte(8'h71, 1'b0);
    go(1'b0);
    chk("un_m", 64'(M), 64'h71);
    F_rtr = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("un_gap_fdr", 64'(F_dr), 64'd0);
      chk("un_gap_eof", 64'(End_of_File), 64'd0);
      tick();
    end
    F_rtr = 1'b0;
    wr_byte(8'h72, 1'b0); wr_byte(8'h73, 1'b1);
    exp_q = '{8'h72, 8'h73};
    collect(1, "un");
    tick();
    finish_digest(64'h7373_7373_7373_7373, "un");

    // reset mid-STREAM after two of four bytes
    wr_byte(8'h81, 1'b0); wr_byte(8'h82, 1'b0); wr_byte(8'h83, 1'b0); wr_byte(8'h84, 1'b1);
    go(1'b0);
    F_rtr = 1'b1;
    tick(); tick();
    F_rtr = 1'b0;
    chk("mid_m", 64'(M), 64'h83);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_outputs("mid_rst");
    wr_byte(8'h91, 1'b0); wr_byte(8'h92, 1'b1);
    exp_q = '{8'h91, 8'h92};
    go(1'b0);
    collect(1, "post");
    tick();
    finish_digest(64'hFEDC_BA98_7654_3210, "post");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/hes_msg_feeder.md
Name: hes_msg_feeder

Overview:
- Producer side of the hash core's message-input handshake (F_dr / F_rtr / start / End_of_File / H_ready).
- Buffers host message bytes in a small FIFO.
- Arms the core with start and streams bytes one per accepted handshake, then raises End_of_File after the last byte.
- Captures the digest when H_ready rises. Sits between the host/bus interface and the hash control/datapath.

Parameters:
DEPTH, 16, FIFO entries (power of two, >= 2)
H_WIDTH, 64, digest width in bits

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
wr_en  input  1  host byte write strobe
wr_data  input  8  host byte
wr_last  input  1  marks wr_data as final byte of message
full  output  1  FIFO full; writes ignored while high
ovf  output  1  sticky: write attempted while full; cleared by rst or accepted cmd_go
cmd_go  input  1  start-message pulse, accepted only in IDLE
cmd_empty  input  1  sampled with cmd_go: message has zero bytes
start  output  1  to core: arm/restart request
F_dr  output  1  to core: M valid
M  output  8  to core: message byte (FIFO head)
F_rtr  input  1  from core: ready to receive
End_of_File  output  1  to core: no more bytes
H_ready  input  1  from core: digest complete
h_in  input  H_WIDTH  from core: digest value
digest  output  H_WIDTH  captured digest
digest_valid  output  1  digest holds result of last message
busy  output  1  state != IDLE

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high.
- Reset: state=IDLE; FIFO emptied; start, F_dr, End_of_File, ovf, digest_valid, busy = 0; digest = 0. Reset mid-message aborts with no digest. The core must be reset or re-armed separately.
- FIFO storage: 9-bit entries {last, byte}.
  - Write occurs when wr_en & !full. Read occurs on handshake (F_dr & F_rtr).
  - No bypass: a byte written into an empty FIFO is visible on M the next cycle.
  - full is evaluated before the same-cycle read, so a write when full is dropped and sets ovf even if a read occurs that cycle.
  - Simultaneous read and write when non-full and non-empty: count unchanged.
  - Pointers are log2(DEPTH)-bit and wrap naturally. Count is log2(DEPTH)+1 bits.
- Writes are accepted in any state, so preloading in IDLE is allowed.
- M = head byte whenever the FIFO is non-empty, otherwise 0.
- FSM states: IDLE, ARM, STREAM, WAIT_H.
  - IDLE: on cmd_go → ARM; clear digest_valid and ovf; latch empty_msg = cmd_empty.
  - ARM: start=1.
    - empty_msg=0: F_dr = FIFO non-empty. On first handshake → STREAM. If that byte has last=1, set eof_flag.
    - empty_msg=1: F_dr=0, End_of_File=1. On F_rtr=1 → WAIT_H.
  - STREAM: start=0. F_dr = FIFO non-empty & !eof_flag.
    - Each handshake pops one byte.
    - A popped byte with last=1 sets eof_flag. End_of_File=1 from the next cycle onward, and F_dr is forced 0.
    - With eof_flag set → WAIT_H the same cycle End_of_File first rises.
  - WAIT_H: End_of_File=1, F_dr=0, start=0.
    - On H_ready=1: digest <= h_in, digest_valid <= 1, → IDLE. End_of_File drops the next cycle.
- F_dr never drops without a handshake while a byte is pending and eof_flag=0. M is stable while F_dr=1 & F_rtr=0.
- Bytes written after the last-marked byte remain in the FIFO for the next message.
- cmd_go outside IDLE is ignored.
- FIFO empty in ARM/STREAM before the last byte: F_dr=0 and wait indefinitely (host underrun, not an error).
- H_ready seen outside WAIT_H is ignored.
- Latency: first-byte handshake can occur the cycle after cmd_go (FIFO preloaded).

Optional Feature:
- Macro: HES_FEED_BYTECNT_EN.
- Defined:
  - Adds output byte_cnt[31:0], cleared on accepted cmd_go and incremented on every handshake (saturates at 2^32-1).
  - Adds output len_err: set in WAIT_H entry if byte_cnt == 0 while empty_msg=0 (cannot normally occur; assertion aid). Cleared on cmd_go.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Preload 3 bytes 0xA1,0xB2,0xC3(last), cmd_go, F_rtr=1 always → start=1 one cycle, M=A1,B2,C3 on consecutive handshakes; End_of_File rises the cycle after the C3 handshake; H_ready with h_in=64'h0123_4567_89AB_CDEF → digest equal, digest_valid=1, busy=0.
- cmd_go with cmd_empty=1, FIFO empty → start=1 and End_of_File=1 together, F_dr=0; F_rtr pulse → WAIT_H; H_ready → digest_valid=1.
- Backpressure: F_rtr toggling 1 of every 8 cycles over a 5-byte message → M and F_dr stable while stalled; exactly 5 handshakes in order.
- Write DEPTH+1 bytes in IDLE → full=1 after DEPTH writes, last byte dropped, ovf=1; next cmd_go clears ovf.
- Streaming underrun: cmd_go with 1 byte (not last), write the remaining 2 bytes 10 cycles later → F_dr=0 during gap, no End_of_File; completes normally.
- rst asserted mid-STREAM after 2 of 4 bytes → next cycle all outputs at reset values, full=0, busy=0; new message then runs correctly.
